// File: rtl/intr_ctl.sv
// intr_ctl -- parametrised interrupt controller for the IO bus.
//
// Latches NSRC interrupt sources. Each source is independently level- or
// edge-triggered, with a per-source enable and a read-to-claim register.
// The controller drives one registered interrupt line to execute.
//
// Optional feature macro: INTR_PRIO_EN
//   When defined, the block adds 2-bit per-source priorities (PRIO at io_addr
//   8/9) and a threshold (THRESH at io_addr 4). When undefined, all sources
//   have equal priority and the lowest index wins.
//
// Register map (io_addr): 0 PEND (W1C), 1 ENABLE, 2 MODE (1=edge), 3 CLAIM (RO),
//                         4 THRESH, 8 PRIO[7:0], 9 PRIO[15:8] (last three with INTR_PRIO_EN)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   src        raw interrupt requests, active high, clk domain
//   io_addr    register index (CPU addr[4:1])
//   io_write   register write strobe
//   io_read    register read strobe (a CLAIM read has a side effect)
//   io_wdata   write data
//   io_rdata   combinational read data
//   interrupt  registered interrupt request
module intr_ctl #(
  parameter int RV   = 16,
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [3:0]      io_addr,
  input  logic            io_write,
  input  logic            io_read,
  input  logic [RV-1:0]   io_wdata,
  output logic [RV-1:0]   io_rdata,
  output logic            interrupt
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pend_r;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] mode;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] mode_nxt;
  logic [NSRC-1:0] pend_nxt;
  logic            win_vld;
  logic [3:0]      win_idx;
  logic [4:0]      claim_val;
  logic            wr_pend, wr_enable, wr_mode, claim;

`ifdef INTR_PRIO_EN
  logic [1:0] prio [NSRC];
  logic [1:0] thresh;
  logic [1:0] best;
  logic       wr_thresh, wr_prio_lo, wr_prio_hi;
`endif

  // Only the low NSRC bits (and with priorities, the PRIO fields) are decoded.
  logic unused_wdata;
  assign unused_wdata = ^io_wdata;

  always_comb begin
    wr_pend   = io_write && (io_addr == 4'd0);
    wr_enable = io_write && (io_addr == 4'd1);
    wr_mode   = io_write && (io_addr == 4'd2);
`ifdef INTR_PRIO_EN
    wr_thresh  = io_write && (io_addr == 4'd4);
    wr_prio_lo = io_write && (io_addr == 4'd8);
    wr_prio_hi = io_write && (io_addr == 4'd9);
`endif

    rise = src & ~src_q;
    // Level sources mirror the registered input directly, so they reach the
    // interrupt line with the same two-clock latency as edge sources.
    pend = (pend_r & mode) | (src_q & ~mode);
    act  = pend & enable;

    // Winner search: ascending scan, a strictly better candidate replaces the
    // current one, so ties resolve to the lowest index.
    win_vld = 1'b0;
    win_idx = '0;
`ifdef INTR_PRIO_EN
    best = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (prio[i] <= thresh) act[i] = 1'b0;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (act[i] && (!win_vld || (prio[i] > best))) begin
        win_vld = 1'b1;
        win_idx = 4'(i);
        best    = prio[i];
      end
    end
`else
    for (int i = 0; i < NSRC; i++) begin
      if (act[i] && !win_vld) begin
        win_vld = 1'b1;
        win_idx = 4'(i);
      end
    end
`endif
    claim_val = win_vld ? ({1'b0, win_idx} + 5'd1) : 5'd0;
    claim     = io_read && (io_addr == 4'd3) && win_vld;

    clr = wr_pend ? io_wdata[NSRC-1:0] : '0;
    for (int i = 0; i < NSRC; i++) begin
      if (claim && (win_idx == 4'(i))) clr[i] = 1'b1;
    end

    mode_nxt = wr_mode ? io_wdata[NSRC-1:0] : mode;
    // Edge latch survives only while the source stays in edge mode; a source
    // entering edge mode starts clear and a set beats a same-cycle clear.
    pend_nxt = (mode & mode_nxt) & (rise | (pend_r & ~clr));
  end

  // Register read mux: old state is returned in a cycle that also writes.
  always_comb begin
    io_rdata = '0;
    case (io_addr)
      4'd0: io_rdata[NSRC-1:0] = pend;
      4'd1: io_rdata[NSRC-1:0] = enable;
      4'd2: io_rdata[NSRC-1:0] = mode;
      4'd3: io_rdata[4:0]      = claim_val;
`ifdef INTR_PRIO_EN
      4'd4: io_rdata[1:0]      = thresh;
      4'd8: for (int i = 0; i < NSRC && i < 8; i++) io_rdata[2*i +: 2] = prio[i];
      4'd9: for (int i = 8; i < NSRC; i++) io_rdata[2*(i-8) +: 2] = prio[i];
`endif
      default: io_rdata = '0;
    endcase
  end

  // ---- state update at clock edge ----
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= '0;
      pend_r    <= '0;
      enable    <= '0;
      mode      <= '0;
      interrupt <= 1'b0;
    end else begin
      src_q     <= src;
      pend_r    <= pend_nxt;
      mode      <= mode_nxt;
      if (wr_enable) enable <= io_wdata[NSRC-1:0];
      interrupt <= |act;
    end
  end

`ifdef INTR_PRIO_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      thresh <= '0;
      for (int i = 0; i < NSRC; i++) prio[i] <= '0;
    end else begin
      if (wr_thresh) thresh <= io_wdata[1:0];
      for (int i = 0; i < NSRC && i < 8; i++) begin
        if (wr_prio_lo) prio[i] <= io_wdata[2*i +: 2];
      end
      for (int i = 8; i < NSRC; i++) begin
        if (wr_prio_hi) prio[i] <= io_wdata[2*(i-8) +: 2];
      end
    end
  end
`endif

endmodule
